// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the dual-issue scoreboard: register file geometry,
// the hardwired-zero register index and the debug stall-reason encoding.
package issue_scoreboard_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [2:0] {
    STALL_NONE      = 3'd0,
    STALL_RAW       = 3'd1,
    STALL_WAW       = 3'd2,
    STALL_PAIR_RAW  = 3'd3,
    STALL_PAIR_WAW  = 3'd4,
    STALL_NOT_READY = 3'd5,
    STALL_FLUSH     = 3'd6
  } stall_reason_e;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/issue bundle between ID and the scoreboard.
//   master : ID stage + regfile write ports (drive slots, wb, flush, ex_ready)
//   slave  : scoreboard (returns issue_1 / issue_2)
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  logic              flush;
  logic              ex_ready;
  logic              valid_1,  valid_2;
  logic [REG_AW-1:0] rs1_1,    rs2_1,    rs1_2,    rs2_2;
  logic              use_rs1_1, use_rs2_1, use_rs1_2, use_rs2_2;
  logic [REG_AW-1:0] rd_1,     rd_2;
  logic              wen_1,    wen_2;
  logic              wb_we_1,  wb_we_2;
  logic [REG_AW-1:0] wb_rd_1,  wb_rd_2;
  logic              issue_1,  issue_2;

  modport master (
    output flush, ex_ready, valid_1, valid_2,
           rs1_1, rs2_1, rs1_2, rs2_2,
           use_rs1_1, use_rs2_1, use_rs1_2, use_rs2_2,
           rd_1, rd_2, wen_1, wen_2,
           wb_we_1, wb_we_2, wb_rd_1, wb_rd_2,
    input  issue_1, issue_2
  );

  modport slave (
    input  flush, ex_ready, valid_1, valid_2,
           rs1_1, rs2_1, rs1_2, rs2_2,
           use_rs1_1, use_rs2_1, use_rs1_2, use_rs2_2,
           rd_1, rd_2, wen_1, wen_2,
           wb_we_1, wb_we_2, wb_rd_1, wb_rd_2,
    output issue_1, issue_2
  );

endinterface

// File: rtl/issue_scoreboard_hazard_check.sv
// Per-slot hazard detection against the registered busy vector.
//   i_busy              pending-write vector
//   i_rs1/i_rs2, i_use_* source indices and their read enables
//   i_rd, i_wen          destination and write enable (WAW check)
//   o_hazard             slot must not issue
//   o_reason             RAW takes precedence over WAW
module issue_scoreboard_hazard_check
  import issue_scoreboard_pkg::*;
(
  input  logic [NUM_REGS-1:0] i_busy,
  input  logic [REG_AW-1:0]   i_rs1,
  input  logic [REG_AW-1:0]   i_rs2,
  input  logic                i_use_rs1,
  input  logic                i_use_rs2,
  input  logic [REG_AW-1:0]   i_rd,
  input  logic                i_wen,
  output logic                o_hazard,
  output stall_reason_e       o_reason
);

  logic w_raw;
  logic w_waw;

  assign w_raw = (i_use_rs1 && (i_rs1 != ZERO_REG) && i_busy[i_rs1]) ||
                 (i_use_rs2 && (i_rs2 != ZERO_REG) && i_busy[i_rs2]);
  assign w_waw = i_wen && (i_rd != ZERO_REG) && i_busy[i_rd];

  assign o_hazard = w_raw | w_waw;
  assign o_reason = w_raw ? STALL_RAW : (w_waw ? STALL_WAW : STALL_NONE);

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard between ID and EX. Tracks registers with a write in
// flight, decides issue for the two decode slots and keeps stall / dual-issue
// performance counters.
//   i_clk, i_rst_n      clock, async active-low reset
//   sb                  decode/writeback/issue bundle (slave side)
//   o_busy              registered pending-write vector (bit 0 always 0)
//   o_stall_cnt         cycles with slot 1 valid but not issued (saturating)
//   o_dual_cnt          cycles with slot 2 issued (saturating)
//   o_reason_1/2        debug: why each slot is held this cycle
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  issue_scoreboard_if.slave   sb,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic [CNT_W-1:0]    o_dual_cnt,
  output stall_reason_e       o_reason_1,
  output stall_reason_e       o_reason_2
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_dual_cnt;
  logic                w_hazard_1, w_hazard_2;
  stall_reason_e       w_hz_reason_1, w_hz_reason_2;
  logic                w_pair_raw, w_pair_waw;
  logic                w_issue_1, w_issue_2;

  issue_scoreboard_hazard_check u_hz_1 (
    .i_busy    (r_busy),
    .i_rs1     (sb.rs1_1),
    .i_rs2     (sb.rs2_1),
    .i_use_rs1 (sb.use_rs1_1),
    .i_use_rs2 (sb.use_rs2_1),
    .i_rd      (sb.rd_1),
    .i_wen     (sb.wen_1),
    .o_hazard  (w_hazard_1),
    .o_reason  (w_hz_reason_1)
  );

  issue_scoreboard_hazard_check u_hz_2 (
    .i_busy    (r_busy),
    .i_rs1     (sb.rs1_2),
    .i_rs2     (sb.rs2_2),
    .i_use_rs1 (sb.use_rs1_2),
    .i_use_rs2 (sb.use_rs2_2),
    .i_rd      (sb.rd_2),
    .i_wen     (sb.wen_2),
    .o_hazard  (w_hazard_2),
    .o_reason  (w_hz_reason_2)
  );

  // Slot 2 cannot see slot 1's result in the same cycle, nor may both
  // claim the same destination.
  assign w_pair_raw = sb.wen_1 && (sb.rd_1 != ZERO_REG) &&
                      ((sb.use_rs1_2 && (sb.rs1_2 == sb.rd_1)) ||
                       (sb.use_rs2_2 && (sb.rs2_2 == sb.rd_1)));
  assign w_pair_waw = sb.wen_1 && sb.wen_2 && (sb.rd_1 == sb.rd_2) &&
                      (sb.rd_1 != ZERO_REG);

  assign w_issue_1 = sb.valid_1 && sb.ex_ready && !sb.flush && !w_hazard_1;
  assign w_issue_2 = w_issue_1 && sb.valid_2 && !w_hazard_2 &&
                     !w_pair_raw && !w_pair_waw;

  assign sb.issue_1 = w_issue_1;
  assign sb.issue_2 = w_issue_2;

  always_comb begin
    o_reason_1 = STALL_NONE;
    if (sb.valid_1) begin
      if (sb.flush)          o_reason_1 = STALL_FLUSH;
      else if (!sb.ex_ready) o_reason_1 = STALL_NOT_READY;
      else                   o_reason_1 = w_hz_reason_1;
    end
  end

  always_comb begin
    o_reason_2 = STALL_NONE;
    if (sb.valid_2 && !w_issue_2) begin
      if (!w_issue_1)       o_reason_2 = (o_reason_1 == STALL_NONE) ? STALL_NOT_READY : o_reason_1;
      else if (w_hazard_2)  o_reason_2 = w_hz_reason_2;
      else if (w_pair_raw)  o_reason_2 = STALL_PAIR_RAW;
      else                  o_reason_2 = STALL_PAIR_WAW;
    end
  end

  // Clears first, then sets: a newer issuer to the same register wins over
  // an older writeback landing on the same edge.
  always_comb begin
    w_busy_nxt = r_busy;
    if (sb.wb_we_1) w_busy_nxt[sb.wb_rd_1] = 1'b0;
    if (sb.wb_we_2) w_busy_nxt[sb.wb_rd_2] = 1'b0;
    if (w_issue_1 && sb.wen_1 && (sb.rd_1 != ZERO_REG)) w_busy_nxt[sb.rd_1] = 1'b1;
    if (w_issue_2 && sb.wen_2 && (sb.rd_2 != ZERO_REG)) w_busy_nxt[sb.rd_2] = 1'b1;
    if (sb.flush) w_busy_nxt = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= '0;
      r_stall_cnt <= '0;
      r_dual_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (sb.valid_1 && !w_issue_1 && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_issue_2 && (r_dual_cnt != '1))
        r_dual_cnt <= r_dual_cnt + CNT_ONE;
    end
  end

  assign o_busy      = r_busy;
  assign o_stall_cnt = r_stall_cnt;
  assign o_dual_cnt  = r_dual_cnt;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller for the two-issue core's register file.
- Tracks which architectural registers have a write in flight and decides each cycle whether decode slot 1, slot 2, both or neither may issue.
- Set side is driven by issue; clear side is driven by the two regfile write ports (reg_write_1/rd_1, reg_write_2/rd_2), mirroring the regfile's write interface.
- Sits between ID and EX; its issue outputs gate the ID/EX pipeline register.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
- REG_AW, 5, register index width, equal to log2(NUM_REGS).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  pipeline flush; clears the scoreboard.
- ex_ready  in  1  EX can accept an issue this cycle.
- valid_1, valid_2  in  1 each  decode slot holds an instruction; slot 1 is older.
- rs1_1, rs2_1, rs1_2, rs2_2  in  REG_AW each  source indices.
- use_rs1_1, use_rs2_1, use_rs1_2, use_rs2_2  in  1 each  source actually read.
- rd_1, rd_2  in  REG_AW each  destination of slot 1 / slot 2.
- wen_1, wen_2  in  1 each  slot writes its rd.
- wb_we_1, wb_we_2  in  1 each  regfile write port enables, same as reg_write_1 and reg_write_2.
- wb_rd_1, wb_rd_2  in  REG_AW each  regfile write destinations.
- issue_1, issue_2  out  1 each  slot issues this cycle (combinational).
- busy  out  NUM_REGS  registered pending-write vector; bit 0 is always 0.
- stall_cnt  out  CNT_W  cycles with valid_1 set and issue_1 clear.
- dual_cnt  out  CNT_W  cycles with issue_2 set.

Behaviour:
- Reset (rst low, async): busy=0, stall_cnt=0, dual_cnt=0. With state reset, issue_1 and issue_2 follow the combinational rules below.
- Hazard for a slot exists when any of these hold:
  - use_rsX is set, rsX is nonzero, and busy[rsX] is set.
  - wen is set, rd is nonzero, and busy[rd] is set (WAW).
- Writeback clears are not bypassed. A register cleared this edge becomes issuable next cycle, because the regfile read is only valid after its write edge.
- Issue rules:
  - issue_1 = valid_1 & ex_ready & ~flush & ~hazard_1.
  - issue_2 = issue_1 & valid_2 & ~hazard_2 & ~pair_raw & ~pair_waw.
  - pair_raw: wen_1 set, rd_1 nonzero, and a used source of slot 2 equals rd_1.
  - pair_waw: wen_1 set, wen_2 set, and rd_1 == rd_2 nonzero.
- Slot 2 never issues without slot 1 (in-order).
- Busy update on each clock edge:
  - Clear busy[wb_rd_k] for each asserted wb_we_k.
  - Then set busy[rd_k] for each issued slot with wen_k set and rd_k nonzero.
  - A set in the same cycle as a clear of the same register wins, because the issuing instruction is newer.
  - Two writebacks to the same rd clear it once; this is not an error.
  - rd = 0 is never set.
- flush: busy is cleared to 0 on the next edge and issue is suppressed that cycle. Flush is asserted only when no writer is in flight beyond the flush point. Issues and writebacks in the flush cycle are ignored for busy.
- Counters:
  - stall_cnt increments when valid_1 is set and issue_1 is clear.
  - dual_cnt increments when issue_2 is set.
  - Both saturate at all-ones and are unaffected by flush.
- Reset mid-operation: everything returns to reset values immediately. The first edge after rst deasserts behaves as from idle.

Decomposition:
- Shared package holds:
  - REG_AW and NUM_REGS.
  - ZERO_REG = 0.
  - A stall-reason enum (NONE, RAW, WAW, PAIR_RAW, PAIR_WAW, NOT_READY, FLUSH), used by debug.
- Sub-module hazard_check, instantiated once per slot: inputs busy, sources, use flags, rd, wen; output hazard and reason.

Test Plan:
- Reset then idle: busy=0, both counters 0. valid_1=valid_2=1 with independent regs (rd_1=3, rd_2=4) and ex_ready=1 gives issue_1=issue_2=1; next cycle busy[3]=busy[4]=1 and dual_cnt=1.
- RAW on busy: busy[5] set, slot 1 rs1=5 → issue_1=0 and stall_cnt increments. When wb_we_1=1 with wb_rd_1=5, issue_1 stays 0 that cycle and becomes 1 the following cycle.
- Intra-pair RAW: slot 1 has rd=7 and wen=1; slot 2 has rs2=7 → issue_1=1, issue_2=0, busy[7]=1 after the edge.
- Same-cycle set and clear: wb_rd_1=9 with slot 1 issuing rd=9 → busy[9]=1 after the edge. A write to rd=0 leaves busy[0]=0.
- Flush and reset: busy=0x0000_0F00, flush=1 → issue_1=0, busy=0 next cycle, counters held. Asserting rst low mid-cycle clears busy and both counters without a clock edge.
